// File: rtl/hc595_rx_capture.sv
// Receive side of the 74HC595 serial link: oversamples shcp/stcp/ds/oe, rebuilds each
// latched word and decodes it into a per-digit segment frame buffer.
module hc595_rx_capture #(
    parameter int CHAIN_W     = 14,
    parameter int SEG_W       = 8,
    parameter int SEL_W       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   shcp,
    input  logic                   stcp,
    input  logic                   ds,
    input  logic                   oe,
    output logic [CHAIN_W-1:0]     par_out,
    output logic                   par_valid,
    output logic [SEG_W-1:0]       seg_vis,
    output logic [SEL_W-1:0]       sel,
    output logic [2:0]             digit_idx,
    output logic                   digit_we,
    output logic [SEG_W*SEL_W-1:0] frame_buf,
    output logic                   frame_done,
    output logic                   len_err,
    output logic                   sel_err
);

    typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;

    // Pin order in each stage: {oe, ds, stcp, shcp}; index 0 is the newest sample.
    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [3:0]                  pin_s;
    logic [1:0]                  prev_q, prev_d;
    logic                        shift_ev_q, shift_ev_d;
    logic                        latch_ev_q, latch_ev_d;
    logic                        ds_ev_q, ds_ev_d;

    logic [CHAIN_W-1:0]     shift_reg_q, shift_reg_d, shift_n;
    logic [4:0]             bit_cnt_q, bit_cnt_d, cnt_n;
    logic [CHAIN_W-1:0]     par_out_q, par_out_d;
    logic                   par_valid_q, par_valid_d;
    logic                   len_err_q, len_err_d;

    state_t                 state_q, state_d;
    logic [CHAIN_W-1:0]     word_q, word_d;
    logic                   pend_q, pend_d;
    logic [CHAIN_W-1:0]     pend_word_q, pend_word_d;
    logic                   sel_err_q, sel_err_d;
    logic [SEG_W*SEL_W-1:0] frame_buf_q, frame_buf_d;
    logic                   digit_we_q, digit_we_d;
    logic [2:0]             digit_idx_q, digit_idx_d;
    logic                   frame_done_q, frame_done_d;

    logic [SEL_W-1:0]       wsel;
    logic [2:0]             widx;
    logic                   onehot;

    assign pin_s = sync_q[SYNC_STAGES-1];

    // Edge events are registered together with ds so the data bit stays aligned to its edge.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], {oe, ds, stcp, shcp}};
        prev_d     = pin_s[1:0];
        shift_ev_d = pin_s[0] & ~prev_q[0];
        latch_ev_d = pin_s[1] & ~prev_q[1];
        ds_ev_d    = pin_s[2];
    end

    // A shift in the same cycle as a latch is applied first and counted before the length check.
    always_comb begin
        shift_n     = shift_ev_q ? {shift_reg_q[CHAIN_W-2:0], ds_ev_q} : shift_reg_q;
        cnt_n       = bit_cnt_q;
        if (shift_ev_q && bit_cnt_q != 5'd31) cnt_n = bit_cnt_q + 5'd1;
        shift_reg_d = shift_n;
        bit_cnt_d   = latch_ev_q ? 5'd0 : cnt_n;
        par_out_d   = latch_ev_q ? shift_n : par_out_q;
        par_valid_d = latch_ev_q;
        len_err_d   = len_err_q | (latch_ev_q && cnt_n != 5'(CHAIN_W));
    end

    always_comb begin
        wsel   = word_q[SEL_W-1:0];
        widx   = 3'd0;
        for (int i = 0; i < SEL_W; i++)
            if (wsel[i]) widx = 3'(i);
        onehot = (wsel != '0) && ((wsel & (wsel - 1'b1)) == '0);
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        pend_d       = pend_q;
        pend_word_d  = pend_word_q;
        sel_err_d    = sel_err_q;
        frame_buf_d  = frame_buf_q;
        digit_we_d   = 1'b0;
        digit_idx_d  = digit_idx_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A fresh word wins over a queued one; the queued word is dropped.
                if (par_valid_q) begin
                    word_d  = par_out_q;
                    pend_d  = 1'b0;
                    state_d = CHECK;
                end else if (pend_q) begin
                    word_d  = pend_word_q;
                    pend_d  = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (onehot) begin
                    state_d = WRITE;
                end else begin
                    sel_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WRITE: begin
                for (int d = 0; d < SEL_W; d++)
                    if (widx == 3'(d)) frame_buf_d[d*SEG_W +: SEG_W] = word_q[CHAIN_W-1:SEL_W];
                digit_we_d   = 1'b1;
                digit_idx_d  = widx;
                frame_done_d = (widx == 3'(SEL_W-1));
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (par_valid_q && state_q != IDLE) begin
            pend_d      = 1'b1;
            pend_word_d = par_out_q;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_q       <= {SYNC_STAGES{4'b1000}};
            prev_q       <= '0;
            shift_ev_q   <= 1'b0;
            latch_ev_q   <= 1'b0;
            ds_ev_q      <= 1'b0;
            shift_reg_q  <= '0;
            bit_cnt_q    <= '0;
            par_out_q    <= '0;
            par_valid_q  <= 1'b0;
            len_err_q    <= 1'b0;
            state_q      <= IDLE;
            word_q       <= '0;
            pend_q       <= 1'b0;
            pend_word_q  <= '0;
            sel_err_q    <= 1'b0;
            frame_buf_q  <= '0;
            digit_we_q   <= 1'b0;
            digit_idx_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            shift_ev_q   <= shift_ev_d;
            latch_ev_q   <= latch_ev_d;
            ds_ev_q      <= ds_ev_d;
            shift_reg_q  <= shift_reg_d;
            bit_cnt_q    <= bit_cnt_d;
            par_out_q    <= par_out_d;
            par_valid_q  <= par_valid_d;
            len_err_q    <= len_err_d;
            state_q      <= state_d;
            word_q       <= word_d;
            pend_q       <= pend_d;
            pend_word_q  <= pend_word_d;
            sel_err_q    <= sel_err_d;
            frame_buf_q  <= frame_buf_d;
            digit_we_q   <= digit_we_d;
            digit_idx_q  <= digit_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign par_out    = par_out_q;
    assign par_valid  = par_valid_q;
    assign seg_vis    = pin_s[3] ? '0 : par_out_q[CHAIN_W-1:SEL_W];
    assign sel        = par_out_q[SEL_W-1:0];
    assign digit_idx  = digit_idx_q;
    assign digit_we   = digit_we_q;
    assign frame_buf  = frame_buf_q;
    assign frame_done = frame_done_q;
    assign len_err    = len_err_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_hc595_rx_capture.sv
// Randomised bench for hc595_rx_capture against a word-level model of the 595 link.
module tb_hc595_rx_capture;

    logic        sys_clk = 1'b0;
    logic        sys_rst, shcp, stcp, ds, oe;
    logic [13:0] par_out;
    logic        par_valid;
    logic [7:0]  seg_vis;
    logic [5:0]  sel;
    logic [2:0]  digit_idx;
    logic        digit_we;
    logic [47:0] frame_buf;
    logic        frame_done;
    logic        len_err, sel_err;

    hc595_rx_capture dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .shcp(shcp), .stcp(stcp), .ds(ds), .oe(oe),
        .par_out(par_out), .par_valid(par_valid), .seg_vis(seg_vis), .sel(sel),
        .digit_idx(digit_idx), .digit_we(digit_we), .frame_buf(frame_buf),
        .frame_done(frame_done), .len_err(len_err), .sel_err(sel_err)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Word-level reference: a list of bits shifted, a bit count, and a digit array.
    logic [13:0] m_shift, m_par;
    int          m_cnt, m_we, m_done, m_last_idx;
    bit          m_len, m_sel;
    logic [7:0]  m_frame [6];

    int          we_cnt = 0;
    int          done_cnt = 0;
    logic [2:0]  last_idx = 3'd0;

    always @(negedge sys_clk) begin
        if (digit_we) begin
            we_cnt++;
            last_idx = digit_idx;
        end
        if (frame_done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic model_reset();
        m_shift = '0;
        m_par   = '0;
        m_cnt   = 0;
        m_len   = 0;
        m_sel   = 0;
        for (int i = 0; i < 6; i++) m_frame[i] = 8'h00;
    endtask

    function automatic logic [47:0] frame_vec();
        logic [47:0] v;
        for (int i = 0; i < 6; i++) v[i*8 +: 8] = m_frame[i];
        return v;
    endfunction

    task automatic model_shift(input bit b);
        m_shift = {m_shift[12:0], b};
        if (m_cnt < 31) m_cnt++;
    endtask

    task automatic model_latch();
        int ones, idx;
        m_par = m_shift;
        if (m_cnt != 14) m_len = 1;
        m_cnt = 0;
        ones = 0;
        idx  = 0;
        for (int i = 0; i < 6; i++)
            if (m_par[i]) begin
                ones++;
                idx = i;
            end
        if (ones == 1) begin
            m_frame[idx] = m_par[13:6];
            m_we++;
            m_last_idx = idx;
            if (idx == 5) m_done++;
        end else begin
            m_sel = 1;
        end
    endtask

    function automatic logic [13:0] rand_word(input bit onehot);
        logic [7:0] s;
        logic [5:0] d;
        s = 8'($urandom);
        d = onehot ? 6'(1 << $urandom_range(5, 0)) : 6'($urandom);
        return {s, d};
    endfunction

    task automatic shift_bit(input bit b);
        ds = b;
        tick(2);
        shcp = 1'b1;
        tick(3);
        shcp = 1'b0;
        tick(2);
        model_shift(b);
    endtask

    task automatic latch_pulse();
        stcp = 1'b1;
        tick(3);
        stcp = 1'b0;
        tick(8);
        model_latch();
    endtask

    task automatic send(input logic [13:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(w[i % 14]);
        latch_pulse();
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick(3);
        sys_rst = 1'b0;
        model_reset();
        tick(2);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (par_out !== 14'h0) begin errors++; $display("FAIL reset_par_out: got %h want 0", par_out); end
        checks++; if (par_valid !== 1'b0 || digit_we !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got %b%b%b want 000", par_valid, digit_we, frame_done); end
        checks++; if (seg_vis !== 8'h0 || sel !== 6'h0) begin
            errors++; $display("FAIL reset_seg_sel: got %h/%h want 0/0", seg_vis, sel); end
        checks++; if (frame_buf !== 48'h0) begin errors++; $display("FAIL reset_frame: got %h want 0", frame_buf); end
        checks++; if (len_err !== 1'b0 || sel_err !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b%b want 00", len_err, sel_err); end
    endtask

    task automatic test_first_word();
        logic [13:0] w;
        int n;
        w = 14'h0FC1;
        for (int i = 13; i >= 0; i--) shift_bit(w[i]);
        stcp = 1'b1;
        n = 0;
        while (n < 12) begin
            tick(1);
            n++;
            if (par_valid === 1'b1) break;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL latch_latency: got %0d clk want 4", n); end
        stcp = 1'b0;
        tick(8);
        model_latch();
        checks++; if (par_out !== 14'h0FC1 || par_out !== m_par) begin
            errors++; $display("FAIL first_par_out: got %h want 0fc1", par_out); end
        checks++; if (frame_buf[7:0] !== 8'h3F) begin errors++; $display("FAIL first_digit0: got %h want 3f", frame_buf[7:0]); end
        checks++; if (we_cnt != m_we || last_idx !== 3'(m_last_idx)) begin
            errors++; $display("FAIL first_we: got cnt %0d idx %0d want cnt %0d idx 0", we_cnt, last_idx, m_we); end
    endtask

    task automatic test_frame();
        logic [7:0] segs [6];
        int done0;
        segs[0] = 8'h06; segs[1] = 8'h5B; segs[2] = 8'h4F;
        segs[3] = 8'h66; segs[4] = 8'h6D; segs[5] = 8'h7D;
        done0 = done_cnt;
        for (int k = 0; k < 6; k++) send({segs[k], 6'(1 << k)}, 14);
        checks++; if (frame_buf !== 48'h7D6D664F5B06 || frame_buf !== frame_vec()) begin
            errors++; $display("FAIL frame_full: got %h want 7d6d664f5b06", frame_buf); end
        checks++; if (done_cnt != done0 + 1 || done_cnt != m_done) begin
            errors++; $display("FAIL frame_done_count: got %0d want %0d", done_cnt - done0, 1); end
        checks++; if (len_err !== 1'b0 || sel_err !== 1'b0) begin
            errors++; $display("FAIL frame_err: got %b%b want 00", len_err, sel_err); end
    endtask

    task automatic test_len_sel();
        logic [47:0] fb0;
        send(rand_word(1), 13);
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_err_set: got %b want 1", len_err); end
        checks++; if (par_out !== m_par) begin errors++; $display("FAIL len_par_out: got %h want %h", par_out, m_par); end
        fb0 = frame_vec();
        send({8'hA5, 6'b000011}, 14);
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL sel_err_set: got %b want 1", sel_err); end
        checks++; if (frame_buf !== fb0 || frame_buf !== frame_vec()) begin
            errors++; $display("FAIL sel_frame_kept: got %h want %h", frame_buf, fb0); end
        checks++; if (par_out !== 14'h2943) begin errors++; $display("FAIL sel_par_out: got %h want 2943", par_out); end
    endtask

    task automatic test_simultaneous();
        logic [13:0] w;
        do_reset();
        w = rand_word(1);
        for (int i = 13; i >= 1; i--) shift_bit(w[i]);
        ds = w[0];
        tick(2);
        shcp = 1'b1;
        stcp = 1'b1;
        tick(3);
        shcp = 1'b0;
        stcp = 1'b0;
        tick(8);
        model_shift(w[0]);
        model_latch();
        checks++; if (par_out !== w) begin errors++; $display("FAIL simul_par_out: got %h want %h", par_out, w); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL simul_len_err: got %b want 0", len_err); end
        checks++; if (frame_buf !== frame_vec() || we_cnt != m_we) begin
            errors++; $display("FAIL simul_write: got %h/%0d want %h/%0d", frame_buf, we_cnt, frame_vec(), m_we); end
    endtask

    task automatic test_oe();
        logic [13:0] w;
        int n;
        oe = 1'b1;
        tick(4);
        w = rand_word(1) | 14'h0040;
        send(w, 14);
        checks++; if (seg_vis !== 8'h00) begin errors++; $display("FAIL oe_blank: got %h want 00", seg_vis); end
        checks++; if (frame_buf !== frame_vec() || par_out !== w) begin
            errors++; $display("FAIL oe_frame: got %h/%h want %h/%h", frame_buf, par_out, frame_vec(), w); end
        oe = 1'b0;
        n = 0;
        while (n < 10) begin
            tick(1);
            n++;
            if (seg_vis === w[13:6]) break;
        end
        checks++; if (n > 3 || seg_vis !== w[13:6]) begin
            errors++; $display("FAIL oe_show: got %h after %0d clk want %h within 3", seg_vis, n, w[13:6]); end
    endtask

    task automatic test_reset_mid();
        logic [13:0] w;
        for (int i = 0; i < 7; i++) shift_bit(1'($urandom));
        #3;
        sys_rst = 1'b1;
        #1;
        checks++; if (par_out !== 14'h0 || frame_buf !== 48'h0 || seg_vis !== 8'h0 || sel !== 6'h0) begin
            errors++; $display("FAIL async_reset: got %h/%h/%h/%h want all 0", par_out, frame_buf, seg_vis, sel); end
        checks++; if (len_err !== 1'b0 || sel_err !== 1'b0 || digit_we !== 1'b0 || par_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset_flags: got %b%b%b%b want 0000", len_err, sel_err, digit_we, par_valid); end
        tick(2);
        sys_rst = 1'b0;
        model_reset();
        tick(2);
        w = rand_word(1);
        send(w, 14);
        checks++; if (par_out !== w || len_err !== 1'b0) begin
            errors++; $display("FAIL post_reset_word: got %h len %b want %h len 0", par_out, len_err, w); end
        checks++; if (frame_buf !== frame_vec() || last_idx !== 3'(m_last_idx)) begin
            errors++; $display("FAIL post_reset_frame: got %h idx %0d want %h idx %0d", frame_buf, last_idx, frame_vec(), m_last_idx); end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 24; it++) begin
            n = ($urandom_range(4, 0) == 0) ? (($urandom_range(1, 0) == 0) ? 13 : 15) : 14;
            send(rand_word($urandom_range(3, 0) != 0), n);
            checks++; if (par_out !== m_par) begin
                errors++; $display("FAIL rand_par_out[%0d]: got %h want %h", it, par_out, m_par); end
            checks++; if (len_err !== m_len || sel_err !== m_sel) begin
                errors++; $display("FAIL rand_err[%0d]: got %b%b want %b%b", it, len_err, sel_err, m_len, m_sel); end
            checks++; if (frame_buf !== frame_vec()) begin
                errors++; $display("FAIL rand_frame[%0d]: got %h want %h", it, frame_buf, frame_vec()); end
            checks++; if (we_cnt != m_we || done_cnt != m_done) begin
                errors++; $display("FAIL rand_counts[%0d]: got %0d/%0d want %0d/%0d", it, we_cnt, done_cnt, m_we, m_done); end
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        shcp = 1'b0;
        stcp = 1'b0;
        ds = 1'b0;
        oe = 1'b0;
        m_we = 0;
        m_done = 0;
        m_last_idx = 0;
        model_reset();
        tick(2);
        test_reset();
        test_first_word();
        test_frame();
        test_len_sel();
        test_simultaneous();
        test_oe();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
